// File: rtl/huffman_pkg.sv
// Shared definitions for the serial Huffman decoder: code-tree states and
// the 3-bit symbol codes driven on the decoder output.
package huffman_pkg;

  typedef enum logic [2:0] {
    ROOT = 3'd0,
    P1   = 3'd1,
    P10  = 3'd2,
    P11  = 3'd3,
    P110 = 3'd4
  } state_t;

  localparam logic [2:0] SYM_NONE = 3'd0;
  localparam logic [2:0] SYM_A    = 3'd1;
  localparam logic [2:0] SYM_B    = 3'd2;
  localparam logic [2:0] SYM_C    = 3'd3;
  localparam logic [2:0] SYM_D    = 3'd4;
  localparam logic [2:0] SYM_E    = 3'd5;
  localparam logic [2:0] SYM_F    = 3'd6;

endpackage

// File: rtl/huffman_decoder.sv
// Serial MSB-first Huffman decoder for symbols A-F; walks the code tree one
// bit per clock and pulses the symbol code for one cycle on completion.
module huffman_decoder
  import huffman_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       x,
  output logic [2:0] y
);

  state_t     state_q, state_d;
  logic [2:0] y_q, y_d;

  always_comb begin
    state_d = ROOT;
    y_d     = SYM_NONE;
    case (state_q)
      ROOT: begin
        if (x) state_d = P1;
        else   y_d     = SYM_A;
      end
      P1:   state_d = x ? P11 : P10;
      P10:  y_d     = x ? SYM_B : SYM_C;
      P11: begin
        if (x) y_d     = SYM_D;
        else   state_d = P110;
      end
      P110: y_d     = x ? SYM_E : SYM_F;
      // Unused encodings fall back to ROOT with no symbol.
      default: begin
        state_d = ROOT;
        y_d     = SYM_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ROOT;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) y_q <= SYM_NONE;
    else        y_q <= y_d;
  end

  assign y = y_q;

endmodule

// File: tb/tb_huffman_decoder.sv
// Self-checking bench for huffman_decoder: fixed code vectors, reset cases and
// random bit streams checked against a codeword-table decoding model.
module tb_huffman_decoder;

  logic       clk;
  logic       reset;
  logic       x;
  logic [2:0] y;

  int n_cmp;
  int n_bad;

  int m_code;
  int m_len;

  huffman_decoder dut (
    .clk   (clk),
    .reset (reset),
    .x     (x),
    .y     (y)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: accumulate bits and look the prefix up in the codeword table.
  function automatic int model_bit(input bit b);
    int lens[6];
    int vals[6];
    lens = '{1, 3, 3, 3, 4, 4};
    vals = '{0, 5, 4, 7, 13, 12};
    m_code = m_code * 2 + int'(b);
    m_len  = m_len + 1;
    for (int k = 0; k < 6; k++) begin
      if (m_len == lens[k] && m_code == vals[k]) begin
        m_code = 0;
        m_len  = 0;
        return k + 1;
      end
    end
    return 0;
  endfunction

  task automatic step(input bit b, output logic [2:0] got);
    x = b;
    @(posedge clk);
    #1;
    got = y;
  endtask

  // Leaves the bench mid-cycle, reset released, model at ROOT.
  task automatic do_reset();
    reset = 1'b0;
    x     = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (y !== 3'd0) begin
      $display("FAIL reset_hold: y=%0d expected 0", y);
      n_bad++;
    end
    #3 reset = 1'b1;
    m_code = 0;
    m_len  = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    x     = 1'b0;
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if (y !== 3'd0) begin
      $display("FAIL reset_async: y=%0d expected 0", y);
      n_bad++;
    end
    do_reset();
  endtask

  task automatic run_vector(input string name, input string bits,
                            input int ev[8], input int sv[8]);
    logic [2:0] got;
    int exp;
    do_reset();
    for (int i = 0; i < bits.len(); i++) begin
      exp = 0;
      for (int k = 0; k < 8; k++)
        if (ev[k] == i + 1) exp = sv[k];
      step(bits[i] == "1", got);
      n_cmp++;
      if (got !== exp[2:0]) begin
        $display("FAIL %s edge %0d: y=%0d expected %0d", name, i + 1, got, exp);
        n_bad++;
      end
    end
  endtask

  task automatic test_vectors();
    int ev[8];
    int sv[8];
    ev = '{4, 8, 12, 15, 18, 19, 23, 27};
    sv = '{6, 5, 5, 4, 3, 1, 6, 5};
    run_vector("FEEDCAFE", {"1100", "1101", "1101", "111", "100", "0", "1100", "1101"}, ev, sv);
    ev = '{3, 7, 8, 11, 14, 18, 22, 26};
    sv = '{4, 5, 1, 4, 2, 5, 5, 6};
    run_vector("DEADBEEF", {"111", "1101", "0", "111", "101", "1101", "1101", "1100"}, ev, sv);
    ev = '{3, 7, 10, 11, 15, 16, 19, 23};
    sv = '{4, 5, 3, 1, 6, 1, 3, 5};
    run_vector("DECAFACE", {"111", "1101", "100", "0", "1100", "0", "100", "1101"}, ev, sv);
  endtask

  task automatic test_back_to_back();
    logic [2:0] got;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b0, got);
      n_cmp++;
      if (got !== 3'd1) begin
        $display("FAIL back_to_back_A edge %0d: y=%0d expected 1", i + 1, got);
        n_bad++;
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [2:0] got;
    do_reset();
    step(1'b0, got);
    n_cmp++;
    if (got !== 3'd1) begin
      $display("FAIL mid_reset_pre: y=%0d expected 1", got);
      n_bad++;
    end
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if (y !== 3'd0) begin
      $display("FAIL mid_reset_async_y: y=%0d expected 0", y);
      n_bad++;
    end
    #3 reset = 1'b1;
    step(1'b1, got);
    step(1'b1, got);
    step(1'b0, got);
    n_cmp++;
    if (got !== 3'd0) begin
      $display("FAIL mid_reset_prefix: y=%0d expected 0", got);
      n_bad++;
    end
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if (y !== 3'd0) begin
      $display("FAIL mid_reset_low: y=%0d expected 0", y);
      n_bad++;
    end
    x = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (y !== 3'd0) begin
      $display("FAIL mid_reset_held: y=%0d expected 0", y);
      n_bad++;
    end
    #3 reset = 1'b1;
    step(1'b0, got);
    n_cmp++;
    if (got !== 3'd1) begin
      $display("FAIL mid_reset_resume: y=%0d expected 1", got);
      n_bad++;
    end
  endtask

  task automatic test_partial();
    logic [2:0] got;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      step(1'b1, got);
      n_cmp++;
      if (got !== 3'd0) begin
        $display("FAIL partial_11 edge %0d: y=%0d expected 0", i + 1, got);
        n_bad++;
      end
    end
    #4;
    n_cmp++;
    if (y !== 3'd0) begin
      $display("FAIL partial_idle: y=%0d expected 0", y);
      n_bad++;
    end
  endtask

  task automatic test_random();
    logic [2:0] got;
    bit b;
    int exp;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      b   = 1'($urandom_range(1, 0));
      exp = model_bit(b);
      step(b, got);
      n_cmp++;
      if (got !== exp[2:0]) begin
        $display("FAIL random bit %0d: y=%0d expected %0d", i, got, exp);
        n_bad++;
      end
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    m_code = 0;
    m_len  = 0;
    test_reset();
    test_vectors();
    test_back_to_back();
    test_mid_reset();
    test_partial();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/huffman_decoder.md
# huffman_decoder

Serial Huffman decoder for the six-symbol alphabet A–F. It consumes one code bit per clock, MSB-first within each codeword, and pulses a 3-bit symbol code for one cycle when a codeword completes. Sits between a serial bit source and any character-level consumer. The output is 0 on cycles where no symbol completes.

## Interface
- No parameters; code table fixed.
- `clk` in 1 — single clock; all state changes on rising edge.
- `reset` in 1 — one clock; reset is asynchronous and active-low.
- `x` in 1 — serial code bit, sampled on each rising `clk`.
- `y` out 3 — decoded symbol: 0 = none, 1 = A, 2 = B, 3 = C, 4 = D, 5 = E, 6 = F; 7 never driven.

## Operation
- Prefix code, first bit first:
  - A = 0
  - B = 101
  - C = 100
  - D = 111
  - E = 1101
  - F = 1100
- Five-state code-tree FSM: ROOT, P1 ("1"), P10, P11, P110.
- Transitions on rising `clk` (x = sampled bit):
  - ROOT: x=0 → emit A, stay ROOT; x=1 → P1.
  - P1: x=0 → P10; x=1 → P11.
  - P10: x=0 → emit C, ROOT; x=1 → emit B, ROOT.
  - P11: x=0 → P110; x=1 → emit D, ROOT.
  - P110: x=0 → emit F, ROOT; x=1 → emit E, ROOT.
- "Emit S" means `y` is registered to S's code on that edge. On every non-emitting edge `y` is registered to 0.
- Codewords are back-to-back with no gaps. The bit after a completing bit is decoded from ROOT.
- An incomplete trailing codeword is held in state indefinitely, with `y` = 0.
- Every state/bit combination is defined, so the FSM has no illegal-input path. Unreachable state encodings recover to ROOT with `y` = 0.

## Timing
- Reset asserted (`reset` = 0): state = ROOT and `y` = 0 immediately, without waiting for a clock edge. Both hold while `reset` is low.
- First bit is sampled on the first rising edge after `reset` deasserts.
- `x` must be stable around each rising edge. The source changes `x` shortly after the edge, well before the next one.
- Latency:
  - `y` shows a symbol starting at the edge that samples the codeword's last bit.
  - It holds for exactly one cycle.
  - It then returns to 0, unless the next bit completes another codeword: consecutive A's give one-cycle pulses with no gap.
- Reset mid-codeword discards the partial prefix. Decoding resumes from ROOT.
- Throughput: one bit per cycle, up to one symbol per cycle.

## Structure
- Shared package `huffman_pkg`:
  - state enum (ROOT, P1, P10, P11, P110);
  - symbol constants SYM_NONE = 0, SYM_A = 1 … SYM_F = 6.
- Single module with one state register and one registered `y`, each in its own sequential block, plus combinational next-state/next-output logic. No sub-module.

## Test plan
Edge numbers are 1-based and count rising edges after reset release. `y` is 0 at every edge not listed.
- FEEDCAFE, bits 1100 1101 1101 111 100 0 1100 1101 (27): `y` = 6@4, 5@8, 5@12, 4@15, 3@18, 1@19, 6@23, 5@27.
- DEADBEEF, bits 111 1101 0 111 101 1101 1101 1100 (26): `y` = 4@3, 5@7, 1@8, 4@11, 2@14, 5@18, 5@22, 6@26.
- DECAFACE, bits 111 1101 100 0 1100 0 100 1101 (23): `y` = 4@3, 5@7, 3@10, 1@11, 6@15, 1@16, 3@19, 5@23.
- Hold `x` = 0 for 8 edges: `y` = 1 after every edge.
- Feed 110, then pull `reset` low mid-cycle: `y` = 0 at once, before any clock edge. Release, then feed 0: `y` = 1 (A), not F.
- Before the first edge after reset, `y` = 0. After a trailing partial code 11, `y` stays 0 across further idle cycles.
